sample_byte_packer: RTL

SAMPLE_BYTE_PACKER -- requirements
Module: sample_byte_packer

---
 rtl/sample_byte_packer_if.sv | 31 +++
 rtl/sample_byte_packer.sv | 116 +++++++++++
 2 files changed

// File: rtl/sample_byte_packer_if.sv
// Handshake and control bundle for sample_byte_packer.
//   start/num_samples/low_res       : run control (in to packer)
//   sample_data/valid/ready         : 12-bit ADC sample stream (in to packer)
//   byte_data/valid/ready           : packed byte stream (out of packer)
//   busy/done                       : run status (out of packer)
// The slave modport is the packer side; master is the driver/consumer side.
interface sample_byte_packer_if #(
  parameter int unsigned pCOUNT_WIDTH = 32
);
  logic                    start;
  logic [pCOUNT_WIDTH-1:0] num_samples;
  logic                    low_res;
  logic [11:0]             sample_data;
  logic                    sample_valid;
  logic                    sample_ready;
  logic [7:0]              byte_data;
  logic                    byte_valid;
  logic                    byte_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output start, num_samples, low_res, sample_data, sample_valid, byte_ready,
    input  sample_ready, byte_data, byte_valid, busy, done
  );

  modport slave (
    input  start, num_samples, low_res, sample_data, sample_valid, byte_ready,
    output sample_ready, byte_data, byte_valid, busy, done
  );
endinterface

// File: rtl/sample_byte_packer.sv
// Packs 12-bit ADC samples into a byte stream.
//   clk_usb : sole clock, rising edge
//   reset   : synchronous, active-high
//   bus     : sample_byte_packer_if.slave (control, sample stream, byte stream, status)
// low_res=1 emits sample[11:4] per sample; low_res=0 packs two samples into
// three bytes, most significant nibble first, padding an odd final sample
// with a zero nibble.
module sample_byte_packer #(
  parameter int unsigned pCOUNT_WIDTH = 32
) (
  input logic                 clk_usb,
  input logic                 reset,
  sample_byte_packer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                  state, state_next;
  logic [pCOUNT_WIDTH-1:0] remaining;
  logic                    mode;
  logic                    phase;
  logic [3:0]              nibble;
  logic [7:0]              stage [3];
  logic [1:0]              count;
  logic                    rem_zero;
  logic                    xfer;
  logic                    pop;

  assign rem_zero = (remaining == '0);
  // Loads only happen when the staging buffer is empty and pops only when it
  // is not, so the two never coincide.
  assign xfer = bus.sample_valid && bus.sample_ready;
  assign pop  = bus.byte_valid && bus.byte_ready;

  always_ff @(posedge clk_usb) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.sample_ready = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.byte_valid   = (count != 2'd0);
    bus.byte_data    = stage[0];
    case (state)
      IDLE: begin
        if (bus.start) state_next = (bus.num_samples == '0) ? DONE : RUN;
      end
      RUN: begin
        bus.busy         = 1'b1;
        bus.sample_ready = !rem_zero && (count == 2'd0);
        if (rem_zero && (count == 2'd0)) state_next = phase ? FLUSH : DONE;
      end
      FLUSH: begin
        bus.busy = 1'b1;
        // phase still set means the pad byte has not been loaded yet
        if (!phase && (count == 2'd0)) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      remaining <= '0;
      mode      <= 1'b0;
      phase     <= 1'b0;
      nibble    <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < 3; i++) stage[i] <= '0;
    end else begin
      if ((state == IDLE) && bus.start) begin
        remaining <= bus.num_samples;
        mode      <= bus.low_res;
        phase     <= 1'b0;
      end

      if (pop) begin
        stage[0] <= stage[1];
        stage[1] <= stage[2];
        count    <= count - 2'd1;
      end

      if (xfer) begin
        remaining <= remaining - pCOUNT_WIDTH'(1);
        if (mode) begin
          stage[0] <= bus.sample_data[11:4];
          count    <= 2'd1;
        end else if (!phase) begin
          stage[0] <= bus.sample_data[11:4];
          nibble   <= bus.sample_data[3:0];
          phase    <= 1'b1;
          count    <= 2'd1;
        end else begin
          stage[0] <= {nibble, bus.sample_data[11:8]};
          stage[1] <= bus.sample_data[7:0];
          phase    <= 1'b0;
          count    <= 2'd2;
        end
      end

      if ((state == FLUSH) && phase) begin
        stage[0] <= {nibble, 4'h0};
        phase    <= 1'b0;
        count    <= 2'd1;
      end
    end
  end

endmodule
